// File: rtl/syn_pipeline_ctrl_if.sv
// Bundle between the pipeline datapath and its hazard/flush/halt controller:
// ID-stage instruction attributes in, pipeline-register controls and counters out.
interface syn_pipeline_ctrl_if #(
    parameter int Stages  = 5,
    parameter int RegBits = 5,
    parameter int CntBits = 32
);
    logic [RegBits-1:0] id_req_a;
    logic [RegBits-1:0] id_req_b;
    logic [RegBits-1:0] id_req_w;
    logic               id_use_a;
    logic               id_use_b;
    logic               id_w_en;
    logic               id_is_load;
    logic               id_halt;
    logic               id_valid;
    logic               ex_redirect;

    logic               stall_if;
    logic               bubble_ex;
    logic               flush_if_id;
    logic               flush_id_ex;
    logic [Stages-1:0]  stage_valid;
    logic               halted;
    logic [CntBits-1:0] retire_cnt;
    logic [CntBits-1:0] stall_cnt;
    logic [CntBits-1:0] flush_cnt;

    modport master (
        output id_req_a, id_req_b, id_req_w, id_use_a, id_use_b,
               id_w_en, id_is_load, id_halt, id_valid, ex_redirect,
        input  stall_if, bubble_ex, flush_if_id, flush_id_ex,
               stage_valid, halted, retire_cnt, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_req_a, id_req_b, id_req_w, id_use_a, id_use_b,
               id_w_en, id_is_load, id_halt, id_valid, ex_redirect,
        output stall_if, bubble_ex, flush_if_id, flush_id_ex,
               stage_valid, halted, retire_cnt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/syn_pipeline_ctrl.sv
// Pipeline controller: tracks in-flight instructions past ID, detects RAW hazards,
// drives stall/bubble/flush, drains on halt and keeps performance counters.
module syn_pipeline_ctrl #(
    parameter int Stages  = 5,
    parameter int RegBits = 5,
    parameter int CntBits = 32,
    parameter bit FwdEn   = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    input logic               en,
    syn_pipeline_ctrl_if.slave bus
);
    localparam int Last = Stages - 1;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    typedef struct packed {
        logic               valid;
        logic               w_en;
        logic [RegBits-1:0] req_w;
        logic               is_load;
        logic               halt;
    } entry_t;

    entry_t [Last:2]    ent_q, ent_d;
    logic [1:0]         state_q, state_d;
    logic [CntBits-1:0] retire_q, retire_d;
    logic [CntBits-1:0] stall_q, stall_d;
    logic [CntBits-1:0] flush_q, flush_d;

    logic              front_frozen;
    logic              step;
    logic              redirect;
    logic              src_a_live, src_b_live;
    logic              hz_raw, hz, bubble;
    logic [Stages-1:0] stage_valid;

    assign front_frozen = (state_q != ST_RUN);
    assign step         = en && (state_q != ST_HALT);
    assign redirect     = bus.ex_redirect && ent_q[2].valid;
    assign src_a_live   = bus.id_use_a && (bus.id_req_a != '0);
    assign src_b_live   = bus.id_use_b && (bus.id_req_b != '0);

    // With forwarding only a load still in EX is unresolved; without it every
    // older writer is, since the register file does not bypass WB into ID.
    // NOTE: every always_comb output gets a default before any conditional write,
    // so no path can leave a latch behind.
    always_comb begin
        hz_raw = 1'b0;
        for (int k = 2; k <= Last; k++) begin
            if (ent_q[k].valid && ent_q[k].w_en &&
                (!FwdEn || (k == 2 && ent_q[k].is_load)) &&
                ((src_a_live && bus.id_req_a == ent_q[k].req_w) ||
                 (src_b_live && bus.id_req_b == ent_q[k].req_w))) begin
                hz_raw = 1'b1;
            end
        end
    end

    assign hz     = hz_raw && bus.id_valid;
    assign bubble = hz && !redirect;

    always_comb begin
        stage_valid    = '0;
        stage_valid[0] = !front_frozen;
        stage_valid[1] = bus.id_valid;
        for (int k = 2; k <= Last; k++) begin
            stage_valid[k] = ent_q[k].valid;
        end
    end

    assign bus.stall_if    = front_frozen || bubble;
    assign bus.bubble_ex   = bubble;
    assign bus.flush_if_id = front_frozen || redirect;
    assign bus.flush_id_ex = redirect;
    assign bus.stage_valid = stage_valid;
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.retire_cnt  = retire_q;
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;

    always_comb begin
        ent_d = ent_q;
        for (int k = Last; k >= 3; k--) begin
            ent_d[k] = ent_q[k-1];
        end
        ent_d[2].valid   = bus.id_valid && !bubble && !redirect;
        ent_d[2].w_en    = bus.id_valid && bus.id_w_en;
        ent_d[2].req_w   = bus.id_valid ? bus.id_req_w : '0;
        ent_d[2].is_load = bus.id_valid && bus.id_is_load;
        ent_d[2].halt    = bus.id_valid && bus.id_halt;

        state_d = state_q;
        if (ent_q[Last].valid && ent_q[Last].halt) begin
            state_d = ST_HALT;
        end else if (ent_d[2].valid && ent_d[2].halt) begin
            state_d = ST_DRAIN;
        end

        retire_d = retire_q + CntBits'(ent_q[Last].valid);
        stall_d  = stall_q + CntBits'(bubble);
        flush_d  = flush_q + CntBits'(redirect);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_q    <= '0;
            state_q  <= ST_RUN;
            retire_q <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else if (step) begin
            ent_q    <= ent_d;
            state_q  <= state_d;
            retire_q <= retire_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end
endmodule

// File: tb/tb_syn_pipeline_ctrl.sv
// Bench for syn_pipeline_ctrl: a forwarding/32-bit-counter instance and a no-forwarding/
// 4-bit-counter instance share one stimulus stream and are compared to a reference model.
module tb_syn_pipeline_ctrl;
    localparam int S  = 5;
    localparam int RB = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    always #5 clk = ~clk;

    syn_pipeline_ctrl_if #(.Stages(S), .RegBits(RB), .CntBits(32)) if_f ();
    syn_pipeline_ctrl_if #(.Stages(S), .RegBits(RB), .CntBits(4))  if_n ();

    assign if_n.id_req_a    = if_f.id_req_a;
    assign if_n.id_req_b    = if_f.id_req_b;
    assign if_n.id_req_w    = if_f.id_req_w;
    assign if_n.id_use_a    = if_f.id_use_a;
    assign if_n.id_use_b    = if_f.id_use_b;
    assign if_n.id_w_en     = if_f.id_w_en;
    assign if_n.id_is_load  = if_f.id_is_load;
    assign if_n.id_halt     = if_f.id_halt;
    assign if_n.id_valid    = if_f.id_valid;
    assign if_n.ex_redirect = if_f.ex_redirect;

    syn_pipeline_ctrl #(.Stages(S), .RegBits(RB), .CntBits(32), .FwdEn(1'b1)) u_fwd (
        .clk(clk), .rst_n(rst_n), .en(en), .bus(if_f)
    );
    syn_pipeline_ctrl #(.Stages(S), .RegBits(RB), .CntBits(4), .FwdEn(1'b0)) u_nofwd (
        .clk(clk), .rst_n(rst_n), .en(en), .bus(if_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: in-flight instructions by stage; model 0 forwards, model 1 does not.
    typedef struct {
        bit v;
        bit w;
        bit ld;
        bit h;
        int rd;
    } ins_t;

    ins_t        mp [2][S];
    bit          m_frz [2];
    bit          m_hlt [2];
    int unsigned m_ret [2];
    int unsigned m_stl [2];
    int unsigned m_fl  [2];

    function automatic bit reads(input int r);
        return (if_f.id_use_a && if_f.id_req_a != 0 && int'(if_f.id_req_a) == r) ||
               (if_f.id_use_b && if_f.id_req_b != 0 && int'(if_f.id_req_b) == r);
    endfunction

    // A producer's result is unavailable to ID if it is a load in EX (forwarding)
    // or anything still in flight (no forwarding).
    function automatic bit m_hz(input int m);
        if (!if_f.id_valid) return 1'b0;
        for (int k = 2; k < S; k++) begin
            if (mp[m][k].v && mp[m][k].w && reads(mp[m][k].rd) &&
                (m == 1 || (k == 2 && mp[m][k].ld)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_redir(input int m);
        return if_f.ex_redirect && mp[m][2].v;
    endfunction

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                for (int k = 0; k < S; k++) mp[m][k] = '{v: 0, w: 0, ld: 0, h: 0, rd: 0};
                m_frz[m] = 0;
                m_hlt[m] = 0;
                m_ret[m] = 0;
                m_stl[m] = 0;
                m_fl[m]  = 0;
            end else if (en && !m_hlt[m]) begin
                bit hz, rdr, fin;
                hz  = m_hz(m);
                rdr = m_redir(m);
                fin = mp[m][S-1].v && mp[m][S-1].h;
                if (mp[m][S-1].v) m_ret[m]++;
                if (hz && !rdr) m_stl[m]++;
                if (rdr) m_fl[m]++;
                for (int k = S-1; k >= 3; k--) mp[m][k] = mp[m][k-1];
                mp[m][2].v  = if_f.id_valid && !(hz && !rdr) && !rdr;
                mp[m][2].w  = if_f.id_valid && if_f.id_w_en;
                mp[m][2].rd = if_f.id_valid ? int'(if_f.id_req_w) : 0;
                mp[m][2].ld = if_f.id_valid && if_f.id_is_load;
                mp[m][2].h  = if_f.id_valid && if_f.id_halt;
                if (mp[m][2].v && mp[m][2].h) m_frz[m] = 1;
                if (fin) m_hlt[m] = 1;
            end
        end
    endtask

    task automatic cmp(input int m, input logic st, bu, fi, fe, input logic [S-1:0] sv,
                       input logic h, input logic [31:0] rc, sc, fc);
        bit hz, rdr;
        logic [S-1:0] e_sv;
        logic [31:0] mask;
        string p;
        hz   = m_hz(m);
        rdr  = m_redir(m);
        mask = (m == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
        p    = (m == 0) ? "fwd" : "nofwd";
        e_sv = '0;
        e_sv[0] = !m_frz[m];
        e_sv[1] = if_f.id_valid;
        for (int k = 2; k < S; k++) e_sv[k] = mp[m][k].v;
        check({p, ".stall_if"},    32'(st), 32'(m_frz[m] || (hz && !rdr)));
        check({p, ".bubble_ex"},   32'(bu), 32'(hz && !rdr));
        check({p, ".flush_if_id"}, 32'(fi), 32'(m_frz[m] || rdr));
        check({p, ".flush_id_ex"}, 32'(fe), 32'(rdr));
        check({p, ".stage_valid"}, 32'(sv), 32'(e_sv));
        check({p, ".halted"},      32'(h),  32'(m_hlt[m]));
        check({p, ".retire_cnt"},  rc, m_ret[m] & mask);
        check({p, ".stall_cnt"},   sc, m_stl[m] & mask);
        check({p, ".flush_cnt"},   fc, m_fl[m] & mask);
    endtask

    task automatic check_all();
        cmp(0, if_f.stall_if, if_f.bubble_ex, if_f.flush_if_id, if_f.flush_id_ex,
            if_f.stage_valid, if_f.halted, if_f.retire_cnt, if_f.stall_cnt, if_f.flush_cnt);
        cmp(1, if_n.stall_if, if_n.bubble_ex, if_n.flush_if_id, if_n.flush_id_ex,
            if_n.stage_valid, if_n.halted, 32'(if_n.retire_cnt), 32'(if_n.stall_cnt),
            32'(if_n.flush_cnt));
    endtask

    // Inputs change at posedge+1; outputs are checked at posedge+2.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_id(input bit v, w, input int dst, input bit ld, h,
                          input bit ua, input int a, input bit ub, input int b);
        if_f.id_valid   = v;
        if_f.id_w_en    = w;
        if_f.id_req_w   = 5'(dst);
        if_f.id_is_load = ld;
        if_f.id_halt    = h;
        if_f.id_use_a   = ua;
        if_f.id_req_a   = 5'(a);
        if_f.id_use_b   = ub;
        if_f.id_req_b   = 5'(b);
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic filler();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if_f.ex_redirect = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        if_f.ex_redirect = 1'b0;
        rst_n = 1'b0;
        en    = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        rst_n = 1'b1;

        // Reset state
        #1;
        check("reset.stage_valid", 32'(if_f.stage_valid), 32'h01);
        check("reset.halted", 32'(if_f.halted), 32'h0);
        check("reset.retire_cnt", if_f.retire_cnt, 32'h0);
        check("reset.stall_cnt", if_f.stall_cnt, 32'h0);
        check("reset.flush_cnt", if_f.flush_cnt, 32'h0);

        // Load-use with forwarding: exactly one stall cycle
        set_id(1, 1, 8, 1, 0, 0, 0, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 1, 8, 0, 0);
        #1;
        check("lu.stall_if", 32'(if_f.stall_if), 32'h1);
        check("lu.bubble_ex", 32'(if_f.bubble_ex), 32'h1);
        tick();
        #1;
        check("lu.stall_if_after", 32'(if_f.stall_if), 32'h0);
        check("lu.stage2_bubble", 32'(if_f.stage_valid[2]), 32'h0);
        check("lu.stall_cnt", if_f.stall_cnt, 32'h1);
        tick();
        idle();
        repeat (4) tick();

        // r0 never creates a hazard
        do_reset();
        set_id(1, 1, 0, 1, 0, 0, 0, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 1, 0, 1, 0);
        #1;
        check("r0.stall_if", 32'(if_f.stall_if), 32'h0);
        check("r0.nofwd_stall_if", 32'(if_n.stall_if), 32'h0);
        tick();
        idle();
        #1;
        check("r0.stall_cnt", if_f.stall_cnt, 32'h0);
        repeat (4) tick();

        // Redirect beats a simultaneous load-use hazard
        do_reset();
        set_id(1, 1, 5, 1, 0, 0, 0, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 0, 0, 1, 5);
        if_f.ex_redirect = 1'b1;
        #1;
        check("sim.flush_if_id", 32'(if_f.flush_if_id), 32'h1);
        check("sim.flush_id_ex", 32'(if_f.flush_id_ex), 32'h1);
        check("sim.stall_if", 32'(if_f.stall_if), 32'h0);
        tick();
        if_f.ex_redirect = 1'b0;
        idle();
        #1;
        check("sim.flush_cnt", if_f.flush_cnt, 32'h1);
        check("sim.stall_cnt", if_f.stall_cnt, 32'h0);
        repeat (4) tick();

        // Halt drain: halt in ID at cycle t, halted visible at t+Stages-1
        do_reset();
        repeat (3) begin
            filler();
            tick();
        end
        set_id(1, 0, 0, 0, 1, 0, 0, 0, 0);
        tick();
        idle();
        #1;
        check("halt.stall_if_t1", 32'(if_f.stall_if), 32'h1);
        check("halt.flush_if_id_t1", 32'(if_f.flush_if_id), 32'h1);
        check("halt.stage0_t1", 32'(if_f.stage_valid[0]), 32'h0);
        tick();
        tick();
        #1;
        check("halt.halted_t3", 32'(if_f.halted), 32'h0);
        tick();
        #1;
        check("halt.halted_t4", 32'(if_f.halted), 32'h1);
        check("halt.retire_cnt", if_f.retire_cnt, 32'h4);
        for (int i = 0; i < 6; i++) begin
            en = i[0];
            set_id(1, 1, 2, 0, 0, 1, 2, 1, 3);
            tick();
        end
        en = 1'b1;
        #1;
        check("halt.frozen_retire", if_f.retire_cnt, 32'h4);
        check("halt.frozen_halted", 32'(if_f.halted), 32'h1);
        check("halt.frozen_nofwd", 32'(if_n.halted), 32'h1);

        // No forwarding: ALU producer in stage 3 stalls ID for two cycles
        do_reset();
        set_id(1, 1, 3, 0, 0, 0, 0, 0, 0);
        tick();
        filler();
        tick();
        set_id(1, 0, 0, 0, 0, 1, 3, 0, 0);
        #1;
        check("nf.stall_c0", 32'(if_n.stall_if), 32'h1);
        check("nf.fwd_no_stall", 32'(if_f.stall_if), 32'h0);
        tick();
        #1;
        check("nf.stall_c1", 32'(if_n.stall_if), 32'h1);
        tick();
        #1;
        check("nf.stall_c2", 32'(if_n.stall_if), 32'h0);
        check("nf.stall_cnt", 32'(if_n.stall_cnt), 32'h2);
        tick();
        idle();
        repeat (4) tick();

        // Counter wrap: 16 retires on the 4-bit instance
        do_reset();
        repeat (16) begin
            filler();
            tick();
        end
        idle();
        repeat (4) tick();
        #1;
        check("wrap.retire_4b", 32'(if_n.retire_cnt), 32'h0);
        check("wrap.retire_32b", if_f.retire_cnt, 32'd16);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (m_hlt[0] && m_hlt[1]) rst_n = ($urandom_range(9) < 3) ? 1'b0 : 1'b1;
            else                      rst_n = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
            en = ($urandom_range(9) != 0);
            set_id($urandom_range(9) < 8, $urandom_range(1), int'($urandom_range(3)),
                   $urandom_range(2) == 0, $urandom_range(99) < 2,
                   $urandom_range(1), int'($urandom_range(3)),
                   $urandom_range(1), int'($urandom_range(3)));
            if_f.ex_redirect = ($urandom_range(9) == 0);
            tick();
        end
        rst_n = 1'b1;
        if_f.ex_redirect = 1'b0;
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
